pe_tile_sched: RTL and testbench



---
 rtl/pe_tile_sched.sv | 190 +++++++++++++++++++
 tb/tb_pe_tile_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_tile_sched.sv
// Tile sequencer for the systolic PE array: clear, skewed FIFO feed, flush, then drain accumulators.
// Feed stalls on any needed empty FIFO; the result drain holds data stable until res_ready.
`timescale 1ns/1ps
module pe_tile_sched #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int KW        = 32,
  parameter int DW        = 32,
  parameter int FLUSH_CYC = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  input  logic [ROWS-1:0] data_empty,
  input  logic [COLS-1:0] weight_empty,
  output logic [ROWS-1:0] data_rd,
  output logic [COLS-1:0] weight_rd,
  output logic            pe_en,
  output logic            pe_clr,
  output logic [3:0]      out_sel,
  input  logic [DW-1:0]   pe_result,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic [3:0]      res_idx
);

  localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
  localparam int NRES  = ROWS * COLS;
  localparam int TW    = KW + 2;
  localparam int FW    = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_SEL,
    S_OUT,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   k_q;
  logic [KW:0]     t_q;
  logic [FW-1:0]   f_q;
  logic [3:0]      idx_q;
  logic [DW-1:0]   res_data_q;
  logic [3:0]      res_idx_q;

  logic [TW-1:0]   t_ext, k_ext;
  logic [ROWS-1:0] need_row;
  logic [COLS-1:0] need_col;
  logic            stall, last_step, advance;

  // Compare in a width two bits wider than K so t < K+r cannot wrap for K = 2^KW-1.
  assign t_ext = {1'b0, t_q};
  assign k_ext = {2'b00, k_q};

  always_comb begin
    need_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      need_row[r] = (t_ext >= TW'(r)) && (t_ext < k_ext + TW'(r));
    end
  end

  always_comb begin
    need_col = '0;
    for (int c = 0; c < COLS; c++) begin
      need_col[c] = (t_ext >= TW'(c)) && (t_ext < k_ext + TW'(c));
    end
  end

  assign stall     = (|(need_row & data_empty)) || (|(need_col & weight_empty));
  assign last_step = (t_ext == k_ext + TW'(MAXRC - 2));

  always_comb begin
    state_nx  = state;
    advance   = 1'b0;
    data_rd   = '0;
    weight_rd = '0;
    pe_en     = 1'b0;
    pe_clr    = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (k_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        pe_clr   = 1'b1;
        state_nx = S_FEED;
      end
      S_FEED: begin
        if (!stall) begin
          advance   = 1'b1;
          data_rd   = need_row;
          weight_rd = need_col;
          pe_en     = 1'b1;
          if (last_step) begin
            state_nx = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        pe_en = 1'b1;
        if (f_q == FW'(FLUSH_CYC - 1)) begin
          state_nx = S_SEL;
        end
      end
      S_SEL: begin
        state_nx = S_OUT;
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nx = (idx_q == 4'(NRES - 1)) ? S_DONE : S_SEL;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k_q        <= '0;
      t_q        <= '0;
      f_q        <= '0;
      idx_q      <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_q <= k_len;
          end
        end
        S_CLEAR: begin
          t_q <= '0;
        end
        S_FEED: begin
          if (advance) begin
            t_q <= t_q + 1'b1;
            if (last_step) begin
              f_q <= '0;
            end
          end
        end
        S_FLUSH: begin
          f_q <= f_q + 1'b1;
          if (f_q == FW'(FLUSH_CYC - 1)) begin
            idx_q <= '0;
          end
        end
        S_SEL: begin
          // out_sel has been stable for a full cycle, so the mux output is settled here.
          res_data_q <= pe_result;
          res_idx_q  <= idx_q;
        end
        S_OUT: begin
          if (res_ready && (idx_q != 4'(NRES - 1))) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_sel  = idx_q;
  assign res_data = res_data_q;
  assign res_idx  = res_idx_q;

endmodule

// File: tb/tb_pe_tile_sched.sv
// Randomized bench for pe_tile_sched against a cycle-level behavioural model of the tile sequence.
`timescale 1ns/1ps
module tb_pe_tile_sched;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KW    = 32;
  localparam int DW    = 32;
  localparam int FLUSH = 7;
  localparam int NRES  = 16;
  localparam int MAXRC = 4;

  localparam int M_IDLE = 0, M_CLEAR = 1, M_FEED = 2, M_FLUSH = 3, M_SEL = 4, M_OUT = 5, M_DONE = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            busy, done, pe_en, pe_clr, res_valid;
  logic            res_ready = 1'b1;
  logic [ROWS-1:0] data_empty = '0;
  logic [COLS-1:0] weight_empty = '0;
  logic [ROWS-1:0] data_rd;
  logic [COLS-1:0] weight_rd;
  logic [3:0]      out_sel, res_idx;
  logic [DW-1:0]   pe_result, res_data;
  logic [DW-1:0]   vals [NRES];

  // The array model: each accumulator holds a per-tile random value.
  assign pe_result = vals[out_sel];

  always #5 clk = ~clk;

  pe_tile_sched #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .DW(DW), .FLUSH_CYC(FLUSH)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .data_empty(data_empty), .weight_empty(weight_empty), .data_rd(data_rd),
    .weight_rd(weight_rd), .pe_en(pe_en), .pe_clr(pe_clr), .out_sel(out_sel),
    .pe_result(pe_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: where the tile is, in terms of the tile's own phases.
  int            m_mode, m_fl, m_sel, m_ridx;
  longint        m_k, m_step;
  logic [DW-1:0] m_data;
  bit            armed = 1'b0;

  int            rd_d [ROWS];
  int            rd_w [COLS];
  int            res_cnt, done_tile, done_total, tiles_run;
  logic [15:0]   seen;

  task automatic model_reset();
    m_mode = M_IDLE; m_fl = 0; m_sel = 0; m_ridx = 0;
    m_k = 0; m_step = 0; m_data = '0;
  endtask

  task automatic sb_clear();
    for (int i = 0; i < ROWS; i++) rd_d[i] = 0;
    for (int i = 0; i < COLS; i++) rd_w[i] = 0;
    res_cnt = 0; done_tile = 0; seen = '0;
  endtask

  always @(negedge clk) begin : monitor
    logic            e_busy, e_done, e_en, e_clr, e_valid, blocked;
    logic [ROWS-1:0] nr;
    logic [COLS-1:0] nc;
    int              n_mode;
    if (armed) begin
      chk("out_sel", 64'(out_sel), 64'(m_sel));
      chk("res_data", 64'(res_data), 64'(m_data));
      chk("res_idx", 64'(res_idx), 64'(m_ridx));
      e_busy = (m_mode != M_IDLE);
      e_done = 1'b0; e_en = 1'b0; e_clr = 1'b0; e_valid = 1'b0;
      nr = '0; nc = '0;
      n_mode = m_mode;
      case (m_mode)
        M_IDLE: if (start) begin
          m_k    = longint'(k_len);
          n_mode = (m_k == 0) ? M_DONE : M_CLEAR;
        end
        M_CLEAR: begin
          e_clr = 1'b1; m_step = 0; n_mode = M_FEED;
        end
        M_FEED: begin
          for (int r = 0; r < ROWS; r++) nr[r] = (m_step >= r) && (m_step < r + m_k);
          for (int c = 0; c < COLS; c++) nc[c] = (m_step >= c) && (m_step < c + m_k);
          blocked = (|(nr & data_empty)) || (|(nc & weight_empty));
          if (blocked) begin
            nr = '0; nc = '0;
          end else begin
            e_en = 1'b1;
            if (m_step == m_k + MAXRC - 2) begin
              n_mode = M_FLUSH; m_fl = 0;
            end
            m_step++;
          end
        end
        M_FLUSH: begin
          e_en = 1'b1; m_fl++;
          if (m_fl == FLUSH) begin
            n_mode = M_SEL; m_sel = 0;
          end
        end
        M_SEL: begin
          m_data = vals[m_sel]; m_ridx = m_sel; n_mode = M_OUT;
        end
        M_OUT: begin
          e_valid = 1'b1;
          if (res_ready) begin
            if (m_sel == NRES - 1) n_mode = M_DONE;
            else begin
              m_sel++; n_mode = M_SEL;
            end
          end
        end
        default: begin
          e_done = 1'b1; n_mode = M_IDLE;
        end
      endcase
      chk("ctl", 64'({busy, done, pe_en, pe_clr, res_valid}), 64'({e_busy, e_done, e_en, e_clr, e_valid}));
      chk("rd", 64'({data_rd, weight_rd}), 64'({nr, nc}));
      m_mode = n_mode;
      for (int r = 0; r < ROWS; r++) if (data_rd[r]) rd_d[r]++;
      for (int c = 0; c < COLS; c++) if (weight_rd[c]) rd_w[c]++;
      if (res_valid && res_ready) begin
        res_cnt++; seen[res_idx] = 1'b1;
      end
      if (done) begin
        done_tile++; done_total++;
      end
    end
    if (rst) begin
      model_reset();
      armed = 1'b1;
    end
  end

  // emp_mode: 0 never empty, 1 random empties, 2 row-2 data FIFO empty for 3 cycles at t=2.
  // rdy_mode: 0 always ready, 1 random, 2 pattern 0,0,1 per result.
  task automatic run_tile(input int k, input int emp_mode, input int rdy_mode, input bit poke);
    int cyc, stall_cnt, wcnt;
    bit timed_out;
    cyc = 0; stall_cnt = 0; wcnt = 0; timed_out = 1'b0;
    for (int i = 0; i < NRES; i++) vals[i] = $urandom;
    sb_clear();
    tiles_run++;
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(k); data_empty = '0; weight_empty = '0; res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      k_len = $urandom;
      start = poke && (m_mode == M_FLUSH || m_mode == M_OUT) && ($urandom_range(0, 1) == 1);
      if (done_tile > 0) begin
        start = 1'b0;
        break;
      end
      if (++cyc > 3000) begin
        timed_out = 1'b1; start = 1'b0;
        break;
      end
      case (emp_mode)
        1: begin
          data_empty   = ROWS'($urandom) & ROWS'($urandom);
          weight_empty = COLS'($urandom) & COLS'($urandom);
        end
        2: begin
          weight_empty = '0;
          if (m_mode == M_FEED && m_step == 2 && stall_cnt < 3) begin
            data_empty = 4'b0100; stall_cnt++;
          end else data_empty = '0;
        end
        default: begin
          data_empty = '0; weight_empty = '0;
        end
      endcase
      case (rdy_mode)
        1: res_ready = ($urandom_range(0, 1) == 1);
        2: begin
          if (m_mode == M_OUT) begin
            res_ready = (wcnt == 2);
            wcnt = (wcnt == 2) ? 0 : wcnt + 1;
          end else begin
            res_ready = 1'b0; wcnt = 0;
          end
        end
        default: res_ready = 1'b1;
      endcase
    end
    data_empty = '0; weight_empty = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("tile_timeout", 64'(timed_out), 64'(0));
    chk("done_cnt", 64'(done_tile), 64'(1));
    chk("res_cnt", 64'(res_cnt), 64'((k == 0) ? 0 : NRES));
    chk("res_seen", 64'(seen), 64'((k == 0) ? 16'h0000 : 16'hFFFF));
    for (int r = 0; r < ROWS; r++) chk("rd_cnt_data", 64'(rd_d[r]), 64'(k));
    for (int c = 0; c < COLS; c++) chk("rd_cnt_weight", 64'(rd_w[c]), 64'(k));
    if (emp_mode == 2) chk("stall_seen", 64'(stall_cnt), 64'(3));
  endtask

  task automatic reset_mid_feed();
    int cyc;
    cyc = 0;
    for (int i = 0; i < NRES; i++) vals[i] = $urandom;
    sb_clear();
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    while (!(m_mode == M_FEED && m_step == 1) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_wait_timeout", 64'(cyc >= 50), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_outs", 64'({busy, done, pe_en, pe_clr, res_valid, data_rd, weight_rd, out_sel, res_idx}), 64'(0));
    chk("rst_data", 64'(res_data), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_result", 64'(res_cnt), 64'(0));
    chk("rst_no_done", 64'(done_tile), 64'(0));
  endtask

  initial begin
    done_total = 0; tiles_run = 0;
    for (int i = 0; i < NRES; i++) vals[i] = '0;
    sb_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outs", 64'({busy, done, pe_en, pe_clr, res_valid, data_rd, weight_rd, out_sel, res_idx}), 64'(0));
    run_tile(3, 0, 0, 1'b0);
    run_tile(0, 0, 0, 1'b0);
    run_tile(2, 2, 0, 1'b0);
    run_tile(4, 0, 2, 1'b0);
    reset_mid_feed();
    run_tile(1, 0, 0, 1'b0);
    run_tile(3, 0, 1, 1'b1);
    for (int n = 0; n < 8; n++) begin
      run_tile($urandom_range(0, 9), 1, 1, 1'b1);
    end
    chk("done_total", 64'(done_total), 64'(tiles_run));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
